// File: rtl/rv_pkg.sv
// Shared encodings for the RV32I decode/execute slice: opcodes, ALU ops and
// immediate/result select codes, plus the funct3 -> ALU op mapping.
package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU  = 2'd0,
    RES_LOAD = 2'd1,
    RES_PC4  = 2'd2
  } result_src_e;

  // alt selects sub for funct3 000 and sra for funct3 101.
  function automatic alu_op_e alu_dec(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv_ctrl_dec.sv
// Combinational main controller: opcode/funct3/funct7[5] to control signals.
// Illegal encodings suppress every side effect and report imm_src = I.
module rv_ctrl_dec (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output logic [2:0] imm_src,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic       mem_write,
  output logic [3:0] alu_op,
  output logic       src_a_zero,
  output logic       src_b_imm,
  output logic       branch,
  output logic       jump,
  output logic       jalr,
  output logic       illegal
);
  import rv_pkg::*;

  always_comb begin
    imm_src    = IMM_I;
    reg_write  = 1'b0;
    result_src = RES_ALU;
    mem_write  = 1'b0;
    alu_op     = ALU_ADD;
    src_a_zero = 1'b0;
    src_b_imm  = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    jalr       = 1'b0;
    illegal    = 1'b0;
    case (opcode)
      OP_R: begin
        reg_write = 1'b1;
        alu_op    = alu_dec(funct3, funct7_b5);
        illegal   = funct7_b5 && (funct3 != 3'b000) && (funct3 != 3'b101);
      end
      OP_I: begin
        // Upper immediate bits only mean "arithmetic" for srai; addi never subtracts.
        reg_write = 1'b1;
        src_b_imm = 1'b1;
        alu_op    = alu_dec(funct3, funct7_b5 && (funct3 == 3'b101));
        illegal   = (funct3 == 3'b001) && funct7_b5;
      end
      OP_LOAD: begin
        reg_write  = 1'b1;
        result_src = RES_LOAD;
        src_b_imm  = 1'b1;
        illegal    = (funct3 != 3'b010);
      end
      OP_STORE: begin
        mem_write = 1'b1;
        src_b_imm = 1'b1;
        imm_src   = IMM_S;
        illegal   = (funct3 != 3'b010);
      end
      OP_BRANCH: begin
        branch  = 1'b1;
        imm_src = IMM_B;
        case (funct3[2:1])
          2'b00:   alu_op  = ALU_SUB;
          2'b10:   alu_op  = ALU_SLT;
          2'b11:   alu_op  = ALU_SLTU;
          default: illegal = 1'b1;
        endcase
      end
      OP_JAL: begin
        jump       = 1'b1;
        reg_write  = 1'b1;
        result_src = RES_PC4;
        imm_src    = IMM_J;
      end
      OP_JALR: begin
        jump       = 1'b1;
        jalr       = 1'b1;
        reg_write  = 1'b1;
        result_src = RES_PC4;
        illegal    = (funct3 != 3'b000);
      end
      OP_LUI: begin
        reg_write  = 1'b1;
        src_a_zero = 1'b1;
        src_b_imm  = 1'b1;
        imm_src    = IMM_U;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      imm_src    = IMM_I;
      reg_write  = 1'b0;
      result_src = RES_ALU;
      mem_write  = 1'b0;
      branch     = 1'b0;
      jump       = 1'b0;
      jalr       = 1'b0;
    end
  end

endmodule

// File: rtl/rv_decode_exec.sv
// RV32I decode/execute slice: controller, ALU, PC+4 and redirect adders feeding
// a 1-cycle registered EX/MEM stage (flush beats stall beats load).
module rv_decode_exec #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  output logic [2:0]      imm_src,
  output logic            reg_write,
  output logic [1:0]      result_src,
  output logic            mem_write,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] write_data,
  output logic [XLEN-1:0] pc_plus_4,
  output logic [XLEN-1:0] pc_target,
  output logic            pc_src,
  output logic            zero,
  output logic            illegal
);
  import rv_pkg::*;

  logic            c_reg_write, c_mem_write, c_illegal;
  logic [1:0]      c_result_src;
  logic [3:0]      alu_op;
  logic            src_a_zero, src_b_imm, branch, jump, jalr;
  logic [XLEN-1:0] src_a, src_b, alu_res, target_sum, target, pc4;
  logic [4:0]      shamt;
  logic            alu_zero, cond, taken;
  logic            unused_bits;

  assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

  rv_ctrl_dec u_ctrl (
    .opcode     (instr[6:0]),
    .funct3     (instr[14:12]),
    .funct7_b5  (instr[30]),
    .imm_src    (imm_src),
    .reg_write  (c_reg_write),
    .result_src (c_result_src),
    .mem_write  (c_mem_write),
    .alu_op     (alu_op),
    .src_a_zero (src_a_zero),
    .src_b_imm  (src_b_imm),
    .branch     (branch),
    .jump       (jump),
    .jalr       (jalr),
    .illegal    (c_illegal)
  );

  assign src_a = src_a_zero ? '0 : rs1_data;
  assign src_b = src_b_imm ? imm : rs2_data;
  assign shamt = src_b[4:0];

  always_comb begin
    case (alu_op)
      ALU_ADD:  alu_res = src_a + src_b;
      ALU_SUB:  alu_res = src_a - src_b;
      ALU_AND:  alu_res = src_a & src_b;
      ALU_OR:   alu_res = src_a | src_b;
      ALU_XOR:  alu_res = src_a ^ src_b;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      ALU_SLL:  alu_res = src_a << shamt;
      ALU_SRL:  alu_res = src_a >> shamt;
      ALU_SRA:  alu_res = XLEN'($signed(src_a) >>> shamt);
      default:  alu_res = '0;
    endcase
  end

  assign alu_zero = (alu_res == '0);
  // funct3[2] picks the compare result over zero; funct3[0] inverts the sense.
  assign cond  = instr[14] ? alu_res[0] : alu_zero;
  assign taken = jump | (branch & (cond ^ instr[12]));

  assign target_sum = (jalr ? rs1_data : pc) + imm;
  assign target     = jalr ? {target_sum[XLEN-1:1], 1'b0} : target_sum;
  assign pc4        = pc + XLEN'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write  <= 1'b0;
      result_src <= 2'b00;
      mem_write  <= 1'b0;
      alu_result <= '0;
      write_data <= '0;
      pc_plus_4  <= '0;
      pc_target  <= '0;
      pc_src     <= 1'b0;
      zero       <= 1'b0;
      illegal    <= 1'b0;
    end else if (flush) begin
      reg_write  <= 1'b0;
      result_src <= 2'b00;
      mem_write  <= 1'b0;
      alu_result <= '0;
      write_data <= '0;
      pc_plus_4  <= '0;
      pc_target  <= '0;
      pc_src     <= 1'b0;
      zero       <= 1'b0;
      illegal    <= 1'b0;
    end else if (!stall) begin
      reg_write  <= c_reg_write;
      result_src <= c_result_src;
      mem_write  <= c_mem_write;
      alu_result <= alu_res;
      write_data <= rs2_data;
      pc_plus_4  <= pc4;
      pc_target  <= target;
      pc_src     <= taken;
      zero       <= alu_zero;
      illegal    <= c_illegal;
    end
  end

endmodule

// File: tb/tb_rv_decode_exec.sv
// Scoreboard bench for rv_decode_exec: a reference model predicts each
// registered result when stimulus is driven; a monitor compares after the edge.
module tb_rv_decode_exec;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, LUI = 7'b0110111;

  logic        clk = 1'b0, rst_n = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [31:0] instr = '0, pc = '0, rs1_data = '0, rs2_data = '0, imm = '0;
  logic [2:0]  imm_src;
  logic        reg_write, mem_write, pc_src, zero, illegal;
  logic [1:0]  result_src;
  logic [31:0] alu_result, write_data, pc_plus_4, pc_target;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rw, mw, ps, ill, z;
    logic [1:0]  rs;
    logic [2:0]  isrc;
    logic [31:0] alu, wd, p4, tgt;
    bit          chk_alu, chk_tgt, chk_rs;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;

  rv_decode_exec #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .instr(instr), .pc(pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .imm_src(imm_src),
    .reg_write(reg_write), .result_src(result_src), .mem_write(mem_write),
    .alu_result(alu_result), .write_data(write_data), .pc_plus_4(pc_plus_4),
    .pc_target(pc_target), .pc_src(pc_src), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
    return {f7, 5'd2, 5'd1, f3, 5'd3, op};
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic exp_t bubble();
    exp_t e = '{default: 0};
    e.chk_alu = 1; e.chk_tgt = 1; e.chk_rs = 1;
    return e;
  endfunction

  function automatic exp_t model(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] m);
    exp_t e = '{default: 0};
    logic [2:0] f3 = i[14:12];
    logic alt = i[30];
    e.wd = b; e.p4 = p + 32'd4; e.chk_alu = 1; e.chk_rs = 1;
    case (i[6:0])
      R:    begin e.ill = alt && !(f3 == 3'd0 || f3 == 3'd5); e.rw = 1; e.alu = alu_ref(f3, alt, a, b); end
      I:    begin e.ill = (f3 == 3'd1) && alt; e.rw = 1; e.alu = alu_ref(f3, alt && f3 == 3'd5, a, m); end
      LD:   begin e.ill = (f3 != 3'd2); e.rw = 1; e.rs = 2'b01; e.alu = a + m; end
      ST:   begin e.ill = (f3 != 3'd2); e.mw = 1; e.isrc = 3'd1; e.alu = a + m; end
      BR: begin
        e.isrc = 3'd2; e.chk_tgt = 1; e.tgt = p + m;
        case (f3)
          3'd0: begin e.alu = a - b; e.ps = (a == b); end
          3'd1: begin e.alu = a - b; e.ps = (a != b); end
          3'd4: begin e.alu = {31'd0, $signed(a) < $signed(b)}; e.ps = ($signed(a) < $signed(b)); end
          3'd5: begin e.alu = {31'd0, $signed(a) < $signed(b)}; e.ps = ($signed(a) >= $signed(b)); end
          3'd6: begin e.alu = {31'd0, a < b}; e.ps = (a < b); end
          3'd7: begin e.alu = {31'd0, a < b}; e.ps = (a >= b); end
          default: e.ill = 1;
        endcase
      end
      JAL:  begin e.isrc = 3'd3; e.rw = 1; e.rs = 2'b10; e.ps = 1; e.tgt = p + m; e.chk_tgt = 1; e.chk_alu = 0; end
      JALR: begin e.ill = (f3 != 3'd0); e.rw = 1; e.rs = 2'b10; e.ps = 1; e.tgt = (a + m) & ~32'd1;
                  e.chk_tgt = 1; e.chk_alu = 0; end
      LUI:  begin e.isrc = 3'd4; e.rw = 1; e.alu = m; end
      default: e.ill = 1;
    endcase
    if (e.ill) begin
      e.rw = 0; e.mw = 0; e.ps = 0; e.isrc = 3'd0; e.chk_alu = 0; e.chk_tgt = 0; e.chk_rs = 0;
    end
    e.z = (e.alu == 32'd0);
    return e;
  endfunction

  task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] m, input logic st, input logic fl);
    exp_t e;
    @(negedge clk);
    instr = i; pc = p; rs1_data = a; rs2_data = b; imm = m; stall = st; flush = fl;
    #1;
    e = model(i, p, a, b, m);
    check_val("imm_src", {29'd0, imm_src}, {29'd0, e.isrc});
    if (fl) e = bubble();
    else if (st) e = last_exp;
    last_exp = e;
    sb.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "/reg_write"}, {31'd0, reg_write}, 32'd0);
    check_val({tag, "/result_src"}, {30'd0, result_src}, 32'd0);
    check_val({tag, "/mem_write"}, {31'd0, mem_write}, 32'd0);
    check_val({tag, "/alu_result"}, alu_result, 32'd0);
    check_val({tag, "/write_data"}, write_data, 32'd0);
    check_val({tag, "/pc_plus_4"}, pc_plus_4, 32'd0);
    check_val({tag, "/pc_target"}, pc_target, 32'd0);
    check_val({tag, "/pc_src"}, {31'd0, pc_src}, 32'd0);
    check_val({tag, "/zero"}, {31'd0, zero}, 32'd0);
    check_val({tag, "/illegal"}, {31'd0, illegal}, 32'd0);
  endtask

  // Monitor: one expected record per loaded clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_val("reg_write", {31'd0, reg_write}, {31'd0, e.rw});
        check_val("mem_write", {31'd0, mem_write}, {31'd0, e.mw});
        check_val("pc_src", {31'd0, pc_src}, {31'd0, e.ps});
        check_val("illegal", {31'd0, illegal}, {31'd0, e.ill});
        check_val("write_data", write_data, e.wd);
        check_val("pc_plus_4", pc_plus_4, e.p4);
        if (e.chk_rs) check_val("result_src", {30'd0, result_src}, {30'd0, e.rs});
        if (e.chk_alu) begin
          check_val("alu_result", alu_result, e.alu);
          check_val("zero", {31'd0, zero}, {31'd0, e.z});
        end
        if (e.chk_tgt) check_val("pc_target", pc_target, e.tgt);
      end
    end
  end

  initial begin
    int k;
    logic [6:0] op;
    last_exp = bubble();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    drive(enc(7'h00, 3'd0, R), 32'h0, 32'd7, 32'd5, 32'h0, 0, 0);                  // add
    drive(enc(7'h20, 3'd0, R), 32'h4, 32'd5, 32'd7, 32'h0, 0, 0);                  // sub
    drive(enc(7'h20, 3'd5, R), 32'h8, 32'h8000_0000, 32'd4, 32'h0, 0, 0);          // sra
    drive(enc(7'h00, 3'd0, BR), 32'h10, 32'd3, 32'd3, 32'h20, 0, 0);               // beq
    drive(enc(7'h00, 3'd6, BR), 32'h14, 32'hFFFF_FFFF, 32'd1, 32'h20, 0, 0);       // bltu
    drive(enc(7'h00, 3'd0, JALR), 32'h40, 32'h101, 32'd9, 32'd4, 0, 0);            // jalr
    drive(enc(7'h00, 3'd2, LD), 32'h44, 32'h100, 32'd9, 32'd8, 0, 0);              // lw
    drive(enc(7'h00, 3'd2, ST), 32'h48, 32'h100, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 0, 0);
    drive(enc(7'h00, 3'd0, LUI), 32'h4C, 32'h55, 32'h66, 32'h1234_5000, 0, 0);
    drive(enc(7'h00, 3'd0, R), 32'h50, 32'd1, 32'd2, 32'h0, 1, 0);                 // stall holds lui
    drive(enc(7'h00, 3'd4, R), 32'h54, 32'd3, 32'd4, 32'h0, 1, 0);
    drive(enc(7'h00, 3'd0, JAL), 32'h58, 32'd3, 32'd4, 32'h8, 1, 1);               // flush wins
    drive(32'h0000_000F, 32'h5C, 32'd1, 32'd2, 32'h0, 0, 0);                       // opcode 0001111
    drive(32'h0000_0000, 32'h60, 32'd1, 32'd2, 32'h0, 0, 0);
    drive(enc(7'h00, 3'd0, R), 32'hFFFF_FFFC, 32'd5, 32'hFFFF_FFFB, 32'h0, 0, 0);  // pc wrap, zero
    drive(enc(7'h00, 3'd0, JAL), 32'hFFFF_FFFC, 32'd0, 32'd0, 32'h8, 0, 0);
    drive(enc(7'h20, 3'd0, I), 32'h64, 32'd10, 32'd0, 32'hFFFF_FC00, 0, 0);        // addi, no sub
    drive(enc(7'h20, 3'd5, I), 32'h68, 32'hF000_0000, 32'd0, 32'h0000_0404, 0, 0); // srai
    drive(enc(7'h20, 3'd1, I), 32'h6C, 32'd1, 32'd0, 32'h0000_0401, 0, 0);         // bad slli
    drive(enc(7'h20, 3'd4, R), 32'h70, 32'd1, 32'd2, 32'h0, 0, 0);                 // bad R funct7
    drive(enc(7'h00, 3'd1, BR), 32'h74, 32'd3, 32'd4, 32'hFFFF_FFF0, 0, 0);        // bne
    drive(enc(7'h00, 3'd4, BR), 32'h78, 32'hFFFF_FFFF, 32'd1, 32'h10, 0, 0);       // blt
    drive(enc(7'h00, 3'd5, BR), 32'h7C, 32'hFFFF_FFFF, 32'd1, 32'h10, 0, 0);       // bge
    drive(enc(7'h00, 3'd7, BR), 32'h80, 32'hFFFF_FFFF, 32'd1, 32'h10, 0, 0);       // bgeu
    drive(enc(7'h00, 3'd2, BR), 32'h84, 32'd1, 32'd1, 32'h10, 0, 0);               // bad branch
    drive(enc(7'h00, 3'd1, JALR), 32'h88, 32'd1, 32'd1, 32'h10, 0, 0);             // bad jalr

    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 1) == 0) ? R : I;
      drive(enc(($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20, 3'($urandom_range(0, 7)), op),
            $urandom, $urandom, $urandom, $urandom, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
    end

    k = 0;
    while (sb.size() != 0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check_val("drain", sb.size(), 32'd0);

    drive(enc(7'h00, 3'd0, JAL), 32'h200, 32'd0, 32'd0, 32'h40, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(posedge clk);
    #1 check_all_zero("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
